// File: rtl/ysyx_25030081_exu_issue.sv
// Issue stage ahead of the ALU: captures decoded instructions with final operands already
// selected, holds up to two of them (main + skid) and presents the main entry to the ALU.
module ysyx_25030081_exu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_alu_op,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1,
    input  logic [DATA_WIDTH-1:0] in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_src1_pc,
    input  logic                  in_src2_imm,
    input  logic [4:0]            in_rd,
    input  logic                  in_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_alu_op,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rd,
    output logic                  out_wen,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    // state = {main_valid, skid_valid}; 2'b01 cannot be reached
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] FULL  = 2'b11;

    typedef struct packed {
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            rd;
        logic                  wen;
    } entry_t;

    logic [1:0] state;
    logic [1:0] state_n;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     new_entry;
    logic       main_valid;
    logic       skid_valid;
    logic       accept;
    logic       drain;
    logic       load_main_new;
    logic       load_main_skid;
    logic       load_skid;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign accept     = in_valid & in_ready;
    assign drain      = main_valid & out_ready;

    // Operands are resolved before storage so the ALU sees only final values
    always_comb begin
        new_entry.alu_op = in_alu_op;
        new_entry.op1    = in_src1_pc  ? in_pc  : in_rs1;
        new_entry.op2    = in_src2_imm ? in_imm : in_rs2;
        new_entry.pc     = in_pc;
        new_entry.rd     = in_rd;
        new_entry.wen    = in_wen & (in_rd != 5'd0);
    end

    always_comb begin
        state_n        = state;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_new = 1'b1;
                        state_n       = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_new = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_n   = FULL;
                    end else if (drain) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_n        = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_n;
            if (load_main_new) begin
                main_q <= new_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    // Stall counter survives flush and saturates rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    assign out_alu_op = main_q.alu_op;
    assign out_op1    = main_q.op1;
    assign out_op2    = main_q.op2;
    assign out_pc     = main_q.pc;
    assign out_rd     = main_q.rd;
    assign out_wen    = main_q.wen;

endmodule
